// File: rtl/apb_v3_master.sv
// apb_v3_master: APB3 master bridge from a valid/ready command port to a SETUP/ACCESS APB bus.
// Define APB_MST_TIMEOUT_EN to abort ACCESS phases that wait TIMEOUT_CYC cycles on PREADY.
`timescale 1ns/1ps
module apb_v3_master #(
    parameter int ADDR_BUS_WIDTH = 32,
    parameter int DATA_BUS_WIDTH = 32,
    parameter int TIMEOUT_CYC    = 64
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_BUS_WIDTH-1:0] cmd_addr,
    input  logic [DATA_BUS_WIDTH-1:0] cmd_wdata,
    output logic                      rsp_valid,
    output logic [DATA_BUS_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_BUS_WIDTH-1:0] PADDR,
    output logic [DATA_BUS_WIDTH-1:0] PWDATA,
    input  logic [DATA_BUS_WIDTH-1:0] PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;
    state_t state, state_nx;
    logic   hs, mis, done, tout;

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be in 1..65535");
    end

    assign hs   = cmd_valid && cmd_ready;
    assign mis  = |(cmd_addr & ADDR_BUS_WIDTH'(DATA_BUS_WIDTH / 8 - 1));
    assign done = (state == ACCESS) && PREADY;

`ifdef APB_MST_TIMEOUT_EN
    logic [15:0] wait_cnt;
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) wait_cnt <= '0;
        else if (state == SETUP) wait_cnt <= '0;
        else if (state == ACCESS && !PREADY) wait_cnt <= wait_cnt + 16'd1;
    end
    // fires on the PREADY-low edge that brings the count to TIMEOUT_CYC
    assign tout = (state == ACCESS) && !PREADY && (wait_cnt == 16'(TIMEOUT_CYC - 1));
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) rsp_timeout <= 1'b0;
        else rsp_timeout <= tout;
    end
`else
    assign tout        = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = hs ? (mis ? ERR : SETUP) : IDLE;
            SETUP:   state_nx = ACCESS;
            ACCESS:  state_nx = (done || tout) ? IDLE : ACCESS;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        PSEL      = (state == SETUP) || (state == ACCESS);
        PENABLE   = (state == ACCESS);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PWRITE <= 1'b0;
            PADDR  <= '0;
            PWDATA <= '0;
        end else if (hs) begin
            PWRITE <= cmd_write;
            PADDR  <= cmd_addr;
            PWDATA <= cmd_wdata;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= done || tout || (state == ERR);
            rsp_err   <= (done && PSLVERR) || tout || (state == ERR);
            rsp_rdata <= (done && !PWRITE && !PSLVERR) ? PRDATA : '0;
        end
    end
endmodule

// File: tb/tb_apb_v3_master.sv
// tb_apb_v3_master: directed bench with a transaction-level model, an APB slave with
// programmable wait states and a per-cycle compare process.
`timescale 1ns/1ps
module tb_apb_v3_master;
    localparam int TO = 4;
    localparam logic [31:0] SRAM_SIZE = 32'h1000;
`ifdef APB_MST_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        PCLK = 1'b0, PRESETn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0, PSLVERR = 1'b0;

    apb_v3_master #(.ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(32), .TIMEOUT_CYC(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int          hs;
        int          rc;
        bit          mis;
        bit          w;
        bit          err;
        bit          to;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];
    int          checks = 0, errors = 0;
    int          cyc = 0, last_hs = 0, s_waits = 0, wcnt = 0;
    bit          run = 1'b0;
    logic [31:0] last_addr = '0;
    bit          last_w = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // slave: holds PREADY low s_waits ACCESS cycles, errors beyond SRAM_SIZE, junk when not ready
    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            if (wcnt == s_waits) begin
                PREADY  = 1'b1;
                PSLVERR = (PADDR >= SRAM_SIZE);
                PRDATA  = (!PWRITE && slv_mem.exists(PADDR)) ? slv_mem[PADDR] : (PWRITE ? 32'hBAD0BAD0 : 32'h0);
                if (PWRITE && !PSLVERR) slv_mem[PADDR] = PWDATA;
            end else begin
                PREADY  = 1'b0;
                PSLVERR = 1'b1;
                PRDATA  = 32'hBAD0BAD0;
            end
            wcnt++;
        end else begin
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            PRDATA  = 32'hBAD0BAD0;
            wcnt    = 0;
        end
    end

    always @(negedge PCLK) begin
        txn_t        t;
        bit          busy, e_psel, e_pen, e_rv, e_w;
        logic [31:0] e_addr, e_rd;
        cyc++;
        if (PRESETn && run) begin
            busy = 0; e_psel = 0; e_pen = 0; e_rv = 0; e_addr = last_addr; e_w = last_w;
            if (q.size() > 0) begin
                t      = q[0];
                busy   = cyc > t.hs && cyc < t.rc;
                e_psel = busy && !t.mis;
                e_pen  = e_psel && cyc > t.hs + 1;
                e_rv   = cyc == t.rc;
                e_addr = t.addr;
                e_w    = t.w;
            end
            chk("cmd_ready", cmd_ready, !busy);
            chk("PSEL", PSEL, e_psel);
            chk("PENABLE", PENABLE, e_pen);
            chk("PADDR", PADDR, e_addr);
            chk("PWRITE", PWRITE, e_w);
            if (e_psel && t.w) chk("PWDATA", PWDATA, t.wdata);
            chk("rsp_valid", rsp_valid, e_rv);
            if (e_rv) begin
                e_rd = (!t.w && !t.err && ref_mem.exists(t.addr)) ? ref_mem[t.addr] : 32'h0;
                chk("rsp_rdata", rsp_rdata, e_rd);
                chk("rsp_err", rsp_err, t.err);
                chk("rsp_timeout", rsp_timeout, t.to);
                if (t.w && !t.err) ref_mem[t.addr] = t.wdata;
                last_addr = t.addr;
                last_w    = t.w;
                void'(q.pop_front());
            end else begin
                chk("rsp_idle", {rsp_rdata[30:0], rsp_err}, 32'h0);
                chk("rsp_idle_top", {rsp_rdata[31], rsp_timeout}, 2'b00);
            end
        end
    end

    task automatic do_cmd(input bit w, input logic [31:0] a, input logic [31:0] d, input int waits, output int hs);
        txn_t t;
        int   n = 0;
        @(negedge PCLK); #1;
        while (!cmd_ready && n < 50) begin
            @(negedge PCLK); #1;
            n++;
        end
        if (!cmd_ready) chk("cmd_ready_wait", cmd_ready, 1'b1);
        s_waits   = waits;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        t.hs    = cyc;
        t.w     = w;
        t.addr  = a;
        t.wdata = d;
        t.mis   = a[1:0] != 2'b00;
        t.to    = TO_EN && !t.mis && waits >= TO;
        t.err   = t.mis || t.to || a >= SRAM_SIZE;
        t.rc    = t.hs + (t.mis ? 2 : 3 + (t.to ? TO - 1 : waits));
        q.push_back(t);
        hs      = t.hs;
        last_hs = t.hs;
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = -1;
        for (int i = 0; i < 100 && lat < 0; i++) begin
            @(negedge PCLK); #2;
            if (rsp_valid) lat = cyc - last_hs;
        end
    endtask

    initial begin
        int h1, h2, h3, lat;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_bus", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout}, 6'b0);
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_pwdata", PWDATA, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        repeat (3) @(negedge PCLK);
        #3 PRESETn = 1'b1;
        run = 1'b1;

        do_cmd(1'b1, 32'h20, 32'hDEADBEEF, 0, h1);
        wait_rsp(lat);
        chk("wr_lat", lat, 3);
        chk("wr_err", rsp_err, 1'b0);
        do_cmd(1'b0, 32'h20, 32'h0, 0, h1);
        wait_rsp(lat);
        chk("rd_lat", lat, 3);
        chk("rd_data", rsp_rdata, 32'hDEADBEEF);
        chk("rd_err", rsp_err, 1'b0);

        do_cmd(1'b1, 32'h40, 32'h12345678, 0, h1);
        do_cmd(1'b0, 32'h40, 32'h0, 3, h1);
        wait_rsp(lat);
        chk("wait_lat", lat, 6);
        chk("wait_data", rsp_rdata, 32'h12345678);

        do_cmd(1'b0, 32'h2, 32'h0, 0, h1);
        wait_rsp(lat);
        chk("mis_lat", lat, 2);
        chk("mis_err", rsp_err, 1'b1);
        chk("mis_data", rsp_rdata, 32'h0);

        do_cmd(1'b1, 32'h2000, 32'h55AA55AA, 1, h1);
        wait_rsp(lat);
        chk("slverr_err", rsp_err, 1'b1);
        chk("slverr_to", rsp_timeout, 1'b0);
        do_cmd(1'b0, 32'h2000, 32'h0, 0, h1);
        wait_rsp(lat);
        chk("slverr_rd", {rsp_err, rsp_rdata[30:0]}, 32'h80000000);

        do_cmd(1'b1, 32'h30, 32'h1, 0, h1);
        do_cmd(1'b1, 32'h34, 32'h2, 0, h2);
        do_cmd(1'b0, 32'h30, 32'h0, 0, h3);
        chk("b2b_gap1", h2 - h1, 3);
        chk("b2b_gap2", h3 - h2, 3);
        wait_rsp(lat);
        chk("b2b_data", rsp_rdata, 32'h1);

        do_cmd(1'b0, 32'h8, 32'h0, 6, h1);
        wait_rsp(lat);
        chk("long_lat", lat, TO_EN ? 6 : 9);
        chk("long_to", rsp_timeout, TO_EN);
        chk("long_err", rsp_err, TO_EN);
        do_cmd(1'b0, 32'h20, 32'h0, 0, h1);
        wait_rsp(lat);
        chk("after_long", rsp_rdata, 32'hDEADBEEF);

        do_cmd(1'b1, 32'h10, 32'hCAFEF00D, 20, h1);
        repeat (4) @(negedge PCLK);
        #3 PRESETn = 1'b0;
        #1;
        chk("rst_mid_psel", {PSEL, PENABLE}, 2'b00);
        chk("rst_mid_rsp", rsp_valid, 1'b0);
        q.delete();
        last_addr = '0;
        last_w    = 1'b0;
        @(negedge PCLK); #3 PRESETn = 1'b1;
        @(negedge PCLK); #1;
        chk("rst_mid_ready", cmd_ready, 1'b1);
        do_cmd(1'b0, 32'h10, 32'h0, 0, h1);
        wait_rsp(lat);
        chk("rst_mid_nowrite", rsp_rdata, 32'h0);
        chk("rst_mid_lat", lat, 3);

        for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge PCLK);
        chk("drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
